// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for the MEM pipeline stage:
//               register-file widths, memory access size encodings, the
//               stage FSM state type and the store lane/alignment helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int RegDataWidth = 32;
    localparam int RegAddrWidth = 5;

    // MemType encodings
    localparam logic [1:0] c_MEM_BYTE = 2'b00;
    localparam logic [1:0] c_MEM_HALF = 2'b01;
    localparam logic [1:0] c_MEM_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Byte enables for a store of the given size at the given byte offset.
    // Half accesses use only offset[1]; a misaligned half is truncated down.
    function automatic logic [3:0] store_be(input logic [1:0] mem_type,
                                            input logic [1:0] offset);
        case (mem_type)
            c_MEM_BYTE: store_be = 4'b0001 << offset;
            c_MEM_HALF: store_be = offset[1] ? 4'b1100 : 4'b0011;
            c_MEM_WORD: store_be = 4'b1111;
            default:    store_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the byte enables alone pick
    // the destination lane.
    function automatic logic [31:0] store_wdata(input logic [1:0]  mem_type,
                                                input logic [31:0] data);
        case (mem_type)
            c_MEM_BYTE: store_wdata = {4{data[7:0]}};
            c_MEM_HALF: store_wdata = {2{data[15:0]}};
            c_MEM_WORD: store_wdata = data;
            default:    store_wdata = data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] mem_type,
                                           input logic [1:0] offset);
        case (mem_type)
            c_MEM_BYTE: is_misaligned = 1'b0;
            c_MEM_HALF: is_misaligned = offset[0];
            c_MEM_WORD: is_misaligned = (offset != 2'b00);
            default:    is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_if
// Description : Data-memory request/acknowledge bus between the MEM stage
//               (master) and the data memory (slave).
//               mem_req/mem_we/mem_addr/mem_wdata/mem_be : master -> slave
//               mem_ack/mem_rdata                        : slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load data extraction. Picks the byte/half lane
//               addressed by the byte offset out of a 32-bit read word and
//               sign- or zero-extends it.
//               i_rdata    : raw word from memory
//               i_offset   : address bits [1:0]
//               i_mem_type : access size (byte/half/word)
//               i_signed   : 1 = sign-extend, 0 = zero-extend
//               o_data     : register-ready load result
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  wire logic [31:0]             i_rdata,
    input  wire logic [1:0]              i_offset,
    input  wire logic [1:0]              i_mem_type,
    input  wire logic                    i_signed,
    output logic      [RegDataWidth-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    // offset[0] is ignored for halves: misaligned halves read the lower lane
    assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = '0;
        case (i_mem_type)
            c_MEM_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            c_MEM_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default:    o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Non-memory ops retire one cycle after
//               acceptance. Loads/stores go IDLE -> BUSY, hold the memory
//               request stable until mem_ack, then retire the next cycle.
//               Ports:
//                 clk, rst (async, active-low)
//                 EX inputs   : valid_EX, data_out_EX, rdata_2_EX, target_EX,
//                               RegWrite_EX, we_hi, we_lo, hi_EX, lo_EX,
//                               is_Overflow, MemRead_EX, MemWrite_EX,
//                               MemType_EX, MemSigned_EX
//                 mem         : data-memory bus (mem_if.master)
//                 WB outputs  : valid_MEM, data_out_MEM, target_MEM,
//                               RegWrite_MEM, we_hi_MEM, we_lo_MEM, hi_MEM,
//                               lo_MEM, stall_MEM, addr_err
//               Optional feature macro: MEM_ALIGN_CHECK_EN - misaligned
//               half/word accesses are rejected with a one-cycle addr_err
//               retirement instead of being truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst,

    input  wire logic                    valid_EX,
    input  wire logic [RegDataWidth-1:0] data_out_EX,
    input  wire logic [RegDataWidth-1:0] rdata_2_EX,
    input  wire logic [RegAddrWidth-1:0] target_EX,
    input  wire logic                    RegWrite_EX,
    input  wire logic                    we_hi,
    input  wire logic                    we_lo,
    input  wire logic [RegDataWidth-1:0] hi_EX,
    input  wire logic [RegDataWidth-1:0] lo_EX,
    input  wire logic                    is_Overflow,
    input  wire logic                    MemRead_EX,
    input  wire logic                    MemWrite_EX,
    input  wire logic [1:0]              MemType_EX,
    input  wire logic                    MemSigned_EX,

    mem_if.master                        mem,

    output logic                         valid_MEM,
    output logic      [RegDataWidth-1:0] data_out_MEM,
    output logic      [RegAddrWidth-1:0] target_MEM,
    output logic                         RegWrite_MEM,
    output logic                         we_hi_MEM,
    output logic                         we_lo_MEM,
    output logic      [RegDataWidth-1:0] hi_MEM,
    output logic      [RegDataWidth-1:0] lo_MEM,
    output logic                         stall_MEM,
    output logic                         addr_err
);

    mem_state_t r_state;
    mem_state_t w_state_next;
    logic       w_busy;

    logic w_accept;
    logic w_mem_op;
    logic w_misaligned;
    logic w_start_access;
    logic w_retire_now;
    logic w_ack_done;

    // Request latched at acceptance; drives the bus while BUSY
    logic [RegDataWidth-1:0] r_req_addr;
    logic [31:0]             r_req_wdata;
    logic [3:0]              r_req_be;
    logic                    r_req_we;
    logic                    r_req_read;
    logic [1:0]              r_req_type;
    logic                    r_req_signed;
    logic [RegAddrWidth-1:0] r_req_target;
    logic                    r_req_regwrite;
    logic                    r_req_we_hi;
    logic                    r_req_we_lo;
    logic [RegDataWidth-1:0] r_req_hi;
    logic [RegDataWidth-1:0] r_req_lo;

    // Retirement registers feeding WB/forwarding
    logic                    r_valid;
    logic [RegDataWidth-1:0] r_data_out;
    logic [RegAddrWidth-1:0] r_target;
    logic                    r_regwrite;
    logic                    r_we_hi;
    logic                    r_we_lo;
    logic [RegDataWidth-1:0] r_hi;
    logic [RegDataWidth-1:0] r_lo;
    logic                    r_addr_err;

    logic [RegDataWidth-1:0] w_load_data;

    assign w_accept   = (r_state == IDLE) && valid_EX;
    assign w_mem_op   = MemRead_EX || MemWrite_EX;
    assign w_ack_done = (r_state == BUSY) && mem.mem_ack;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_mem_op && is_misaligned(MemType_EX, data_out_EX[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // Overflow and rejected alignment both skip the bus entirely
    assign w_start_access = w_accept && w_mem_op && !is_Overflow && !w_misaligned;
    assign w_retire_now   = w_accept && !w_start_access;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_access) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_busy = 1'b1;
                if (mem.mem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    load_align u_load_align (
        .i_rdata    (mem.mem_rdata),
        .i_offset   (r_req_addr[1:0]),
        .i_mem_type (r_req_type),
        .i_signed   (r_req_signed),
        .o_data     (w_load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_addr     <= '0;
            r_req_wdata    <= '0;
            r_req_be       <= '0;
            r_req_we       <= 1'b0;
            r_req_read     <= 1'b0;
            r_req_type     <= '0;
            r_req_signed   <= 1'b0;
            r_req_target   <= '0;
            r_req_regwrite <= 1'b0;
            r_req_we_hi    <= 1'b0;
            r_req_we_lo    <= 1'b0;
            r_req_hi       <= '0;
            r_req_lo       <= '0;
            r_valid        <= 1'b0;
            r_data_out     <= '0;
            r_target       <= '0;
            r_regwrite     <= 1'b0;
            r_we_hi        <= 1'b0;
            r_we_lo        <= 1'b0;
            r_hi           <= '0;
            r_lo           <= '0;
            r_addr_err     <= 1'b0;
        end else begin
            // Write strobes pulse with valid so a retired op is written once
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_we_hi    <= 1'b0;
            r_we_lo    <= 1'b0;
            r_addr_err <= 1'b0;

            if (w_accept) begin
                r_req_addr     <= data_out_EX;
                r_req_wdata    <= store_wdata(MemType_EX, rdata_2_EX);
                r_req_be       <= store_be(MemType_EX, data_out_EX[1:0]);
                r_req_we       <= MemWrite_EX;
                r_req_read     <= MemRead_EX;
                r_req_type     <= MemType_EX;
                r_req_signed   <= MemSigned_EX;
                r_req_target   <= target_EX;
                r_req_regwrite <= RegWrite_EX;
                r_req_we_hi    <= we_hi;
                r_req_we_lo    <= we_lo;
                r_req_hi       <= hi_EX;
                r_req_lo       <= lo_EX;

                if (w_retire_now) begin
                    r_valid    <= 1'b1;
                    r_data_out <= data_out_EX;
                    r_target   <= target_EX;
                    r_regwrite <= RegWrite_EX && !is_Overflow && !w_misaligned;
                    r_we_hi    <= we_hi;
                    r_we_lo    <= we_lo;
                    r_hi       <= hi_EX;
                    r_lo       <= lo_EX;
                    r_addr_err <= w_misaligned;
                end
            end else if (w_ack_done) begin
                r_valid    <= 1'b1;
                r_data_out <= r_req_read ? w_load_data : r_req_addr;
                r_target   <= r_req_target;
                r_regwrite <= r_req_regwrite;
                r_we_hi    <= r_req_we_hi;
                r_we_lo    <= r_req_we_lo;
                r_hi       <= r_req_hi;
                r_lo       <= r_req_lo;
            end
        end
    end

    // Request is a decode of the state register, so reset drops it at once
    assign mem.mem_req   = w_busy;
    assign mem.mem_we    = r_req_we;
    assign mem.mem_addr  = {r_req_addr[31:2], 2'b00};
    assign mem.mem_wdata = r_req_wdata;
    assign mem.mem_be    = r_req_be;

    assign stall_MEM    = w_busy;
    assign valid_MEM    = r_valid;
    assign data_out_MEM = r_data_out;
    assign target_MEM   = r_target;
    assign RegWrite_MEM = r_regwrite;
    assign we_hi_MEM    = r_we_hi;
    assign we_lo_MEM    = r_we_lo;
    assign hi_MEM       = r_hi;
    assign lo_MEM       = r_lo;
    assign addr_err     = r_addr_err;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs from EX: valid_EX 1, data_out_EX RegDataWidth (ALU result/address), rdata_2_EX RegDataWidth (store data), target_EX RegAddrWidth, RegWrite_EX 1, we_hi 1, we_lo 1, hi_EX RegDataWidth, lo_EX RegDataWidth, is_Overflow 1.
REQ-004 SHALL have memory-control inputs: MemRead_EX 1, MemWrite_EX 1, MemType_EX 2 (00 byte, 01 half, 10 word), MemSigned_EX 1.
REQ-005 SHALL have data-memory bus: mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_ack in 1, mem_rdata in 32.
REQ-006 SHALL have outputs to WB and forwarding: valid_MEM 1, data_out_MEM RegDataWidth, target_MEM RegAddrWidth, RegWrite_MEM 1, we_hi_MEM 1, we_lo_MEM 1, hi_MEM RegDataWidth, lo_MEM RegDataWidth, stall_MEM 1, addr_err 1.

Function
REQ-007 SHALL implement FSM states IDLE and BUSY.
REQ-008 In IDLE with valid_EX=1 and neither MemRead_EX nor MemWrite_EX: register all EX values; valid_MEM=1 next cycle; latency 1; stall_MEM stays 0.
REQ-009 In IDLE with valid_EX=1 and MemRead_EX or MemWrite_EX: latch the request, go to BUSY; valid_MEM=0 next cycle.
REQ-010 In BUSY, mem_req SHALL be held 1 with mem_addr, mem_we, mem_wdata and mem_be stable until mem_ack=1; stall_MEM=1 throughout BUSY.
REQ-011 On mem_ack=1 in BUSY: return to IDLE; next cycle valid_MEM=1, and for loads data_out_MEM = aligned load data, else the latched data_out_EX.
REQ-012 mem_ack=1 in the first BUSY cycle SHALL give a 2-cycle total latency; mem_ack in IDLE SHALL be ignored.
REQ-013 Store lanes: byte -> mem_be=0001<<addr[1:0], wdata = byte replicated x4; half -> mem_be=0011<<(2*addr[1]), wdata = half replicated x2; word -> mem_be=1111.
REQ-014 Loads SHALL select the lane by addr[1:0], then sign-extend if MemSigned_EX=1, else zero-extend.
REQ-015 mem_addr SHALL be {data_out_EX[31:2],2'b00}; mem_we=MemWrite_EX.
REQ-016 is_Overflow=1 SHALL suppress the access and RegWrite_MEM; the op still completes in 1 cycle with valid_MEM=1.
REQ-017 valid_EX and EX inputs SHALL be ignored while BUSY; upstream holds them under stall_MEM.
REQ-018 valid_MEM SHALL be a 1-cycle pulse per retired op.

Reset
REQ-019 rst=0 SHALL force IDLE and clear every output and register to 0, including mid-BUSY; mem_req drops the same instant.
REQ-020 The first rising edge after rst deasserts SHALL accept a new op.

Configuration
REQ-021 With MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL take no BUSY, assert no mem_req, clear RegWrite_MEM, and pulse addr_err=1 with valid_MEM=1 next cycle.
REQ-022 Without MEM_ALIGN_CHECK_EN: addr_err SHALL be tied 0; misaligned addresses are truncated per REQ-013/015.

Structure
REQ-023 A shared package mem_pkg SHALL hold RegDataWidth=32, RegAddrWidth=5, MemType encodings and the FSM state enum.
REQ-024 Load extraction/extension SHALL be a combinational sub-module load_align; all other logic is in mem_stage.

Verification
REQ-025 ALU op data_out_EX=0x12345678, target_EX=5, RegWrite_EX=1 -> next cycle valid_MEM=1, data_out_MEM=0x12345678, target_MEM=5, stall_MEM=0.
REQ-026 Signed byte load addr=0x103, mem_ack after 3 cycles, mem_rdata=0x80FFFFFF -> stall_MEM=1 for 3 cycles, then data_out_MEM=0xFFFFFF80.
REQ-027 Half store addr=0x102, rdata_2_EX=0xAAAABEEF -> mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1 until ack.
REQ-028 rst=0 mid-BUSY -> mem_req=0 immediately; after release a new ALU op retires in 1 cycle.
REQ-029 With MEM_ALIGN_CHECK_EN, word load addr=0x101 -> no mem_req, addr_err=1, RegWrite_MEM=0, valid_MEM=1.
REQ-030 is_Overflow=1 with MemWrite_EX=1 -> no mem_req, RegWrite_MEM=0, valid_MEM=1 next cycle.
